// File: rtl/pix_stream_source_if.sv
// Pixel-stream source bundle: upstream valid/ready pixel feed plus framed output.
// Latency: none (wires only).
// Backpressure: src_ready is driven by the source block, src_valid by the upstream buffer.
interface pix_stream_source_if;
    logic        enable;
    logic        src_valid;
    logic [23:0] src_data;
    logic        src_ready;
    logic        per_frame_vsync;
    logic        per_frame_href;
    logic        per_frame_clken;
    logic [23:0] pix_data_out;
    logic        frame_busy;
    logic        frame_done;

    // Frame-timing source side
    modport master (
        input  enable, src_valid, src_data,
        output src_ready, per_frame_vsync, per_frame_href, per_frame_clken,
        output pix_data_out, frame_busy, frame_done
    );

    // Upstream buffer / downstream consumer side
    modport slave (
        output enable, src_valid, src_data,
        input  src_ready, per_frame_vsync, per_frame_href, per_frame_clken,
        input  pix_data_out, frame_busy, frame_done
    );
endinterface

// File: rtl/pix_stream_source.sv
// Frame-timing transmitter: pulls RGB888 pixels and emits vsync/href/clken framing.
// Latency: 1 cycle from accepted pixel to pix_data_out/clken; framing outputs registered.
// Backpressure: src_ready high only in LINE with pixels left; a src_valid gap holds href, drops clken.
module pix_stream_source #(
    parameter logic [9:0]  IMG_HDISP = 10'd640,
    parameter logic [9:0]  IMG_VDISP = 10'd480,
    parameter logic [15:0] H_BLANK   = 16'd160,
    parameter logic [15:0] V_PRE     = 16'd1000,
    parameter logic [15:0] V_POST    = 16'd1000,
    parameter logic [15:0] V_GAP     = 16'd2000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    pix_stream_source_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_V_PRE,
        S_LINE,
        S_H_BLANK,
        S_V_POST,
        S_V_GAP
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] blank_cnt, blank_nxt;
    logic [9:0]  pix_cnt, pix_nxt;
    logic [9:0]  line_cnt, line_nxt;
    logic        done_nxt;
    logic        src_ready;
    logic        xfer;

    logic        vsync_q, href_q, clken_q, busy_q, done_q;
    logic [23:0] data_q;

    // pix_cnt never reaches IMG_HDISP inside LINE (the last transfer leaves the
    // state), but the compare keeps ready honest if that ever changes.
    assign src_ready = (state == S_LINE) && (pix_cnt < IMG_HDISP);
    assign xfer      = src_ready && bus.src_valid;

    // State and counter registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= S_IDLE;
            blank_cnt <= 16'd0;
            pix_cnt   <= 10'd0;
            line_cnt  <= 10'd0;
        end else begin
            state     <= state_nxt;
            blank_cnt <= blank_nxt;
            pix_cnt   <= pix_nxt;
            line_cnt  <= line_nxt;
        end
    end

    // Next-state logic; blank_cnt counts 0..N-1 in each timed state and is
    // cleared on every exit so the next timed state starts from zero.
    always_comb begin
        state_nxt = state;
        blank_nxt = blank_cnt;
        pix_nxt   = pix_cnt;
        line_nxt  = line_cnt;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.enable) begin
                    state_nxt = S_V_PRE;
                    blank_nxt = 16'd0;
                end
            end
            S_V_PRE: begin
                if (blank_cnt == V_PRE - 16'd1) begin
                    state_nxt = S_LINE;
                    blank_nxt = 16'd0;
                    line_nxt  = 10'd0;
                    pix_nxt   = 10'd0;
                end else begin
                    blank_nxt = blank_cnt + 16'd1;
                end
            end
            S_LINE: begin
                if (xfer) begin
                    if (pix_cnt == IMG_HDISP - 10'd1) begin
                        state_nxt = S_H_BLANK;
                        pix_nxt   = 10'd0;
                        line_nxt  = line_cnt + 10'd1;
                        blank_nxt = 16'd0;
                    end else begin
                        pix_nxt = pix_cnt + 10'd1;
                    end
                end
            end
            S_H_BLANK: begin
                if (blank_cnt == H_BLANK - 16'd1) begin
                    blank_nxt = 16'd0;
                    state_nxt = (line_cnt < IMG_VDISP) ? S_LINE : S_V_POST;
                end else begin
                    blank_nxt = blank_cnt + 16'd1;
                end
            end
            S_V_POST: begin
                if (blank_cnt == V_POST - 16'd1) begin
                    blank_nxt = 16'd0;
                    state_nxt = S_V_GAP;
                    done_nxt  = 1'b1;
                end else begin
                    blank_nxt = blank_cnt + 16'd1;
                end
            end
            S_V_GAP: begin
                if (blank_cnt == V_GAP - 16'd1) begin
                    blank_nxt = 16'd0;
                    state_nxt = bus.enable ? S_V_PRE : S_IDLE;
                end else begin
                    blank_nxt = blank_cnt + 16'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                blank_nxt = 16'd0;
                pix_nxt   = 10'd0;
                line_nxt  = 10'd0;
            end
        endcase
    end

    // Framing outputs, one cycle behind the state/handshake that causes them
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            clken_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= 24'd0;
        end else begin
            vsync_q <= (state == S_V_PRE) || (state == S_LINE) ||
                       (state == S_H_BLANK) || (state == S_V_POST);
            href_q  <= (state == S_LINE);
            clken_q <= xfer;
            busy_q  <= (state != S_IDLE);
            done_q  <= done_nxt;
            if (xfer) begin
                data_q <= bus.src_data;
            end
        end
    end

    assign bus.src_ready       = src_ready;
    assign bus.per_frame_vsync = vsync_q;
    assign bus.per_frame_href  = href_q;
    assign bus.per_frame_clken = clken_q;
    assign bus.pix_data_out    = data_q;
    assign bus.frame_busy      = busy_q;
    assign bus.frame_done      = done_q;

endmodule

// File: tb/tb_pix_stream_source.sv
// Directed bench for pix_stream_source with a 4x3 frame and short blanking.
// Latency: outputs sampled on the falling edge, inputs driven just after it.
// Backpressure: upstream model stalls every 3rd ready cycle in the stall scenario.
module tb_pix_stream_source;

    logic sys_clk = 1'b0;
    logic sys_rst;

    pix_stream_source_if bus ();

    pix_stream_source #(
        .IMG_HDISP (10'd4),
        .IMG_VDISP (10'd3),
        .H_BLANK   (16'd2),
        .V_PRE     (16'd5),
        .V_POST    (16'd5),
        .V_GAP     (16'd3)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0;
    int n_pass = 0;

    // upstream / stimulus state
    int   mode;        // 0: valid always, 1: stall every 3rd ready cycle while measuring, 2: idle/random data
    int   drop_at;     // measured cycle at which enable is dropped (-1: never)
    int   ready_cnt;
    logic xfer_pend;
    int   pix_exp;

    // measurement state
    logic armed, meas;
    int   cyc;
    int   n_vs, n_href, n_clk, n_done, done_at, n_busy, n_ready, ne_cnt, inv_err, hlen;
    int   rises[$];
    int   hlens[$];
    logic vs_prev, href_prev;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic clear_stats();
        cyc = 0; n_vs = 0; n_href = 0; n_clk = 0; n_done = 0; done_at = -1;
        n_busy = 0; n_ready = 0; ne_cnt = 0; inv_err = 0; hlen = 0;
        rises.delete();
        hlens.delete();
    endtask

    task automatic step();
        logic vs, hr, ck;
        @(negedge sys_clk);
        if (xfer_pend) bus.src_data = bus.src_data + 24'd1;
        vs = bus.per_frame_vsync;
        hr = bus.per_frame_href;
        ck = bus.per_frame_clken;
        if (armed && vs && !vs_prev) begin
            armed = 1'b0; meas = 1'b1; cyc = 0; ready_cnt = 0;
        end
        if (meas) begin
            if (vs) n_vs++;
            if (hr) begin n_href++; hlen++; end
            if (hr && !href_prev) rises.push_back(cyc);
            if (!hr && href_prev) begin hlens.push_back(hlen); hlen = 0; end
            if (ck) n_clk++;
            if (ck != hr) ne_cnt++;
            if ((ck && !hr) || (hr && !vs)) inv_err++;
            if (bus.frame_done) begin n_done++; done_at = cyc; end
            if (bus.frame_busy) n_busy++;
            if (bus.src_ready) n_ready++;
            cyc++;
        end
        if (ck) begin
            chk("pix_data", int'(bus.pix_data_out), pix_exp);
            pix_exp++;
        end
        vs_prev = vs;
        href_prev = hr;
        if (meas && cyc == drop_at) bus.enable = 1'b0;
        if (mode == 2) begin
            bus.src_valid = 1'b1;
            bus.src_data  = 24'($urandom);
        end else if (mode == 1 && meas && bus.src_ready) begin
            ready_cnt++;
            bus.src_valid = (ready_cnt % 3 != 0);
        end else begin
            bus.src_valid = 1'b1;
        end
        xfer_pend = bus.src_valid && bus.src_ready;
    endtask

    // Arm on the next vsync rise, then record n cycles starting with that rise.
    task automatic measure(input int n, input int timeout);
        int t;
        clear_stats();
        armed = 1'b1;
        meas  = 1'b0;
        t = 0;
        while (!(meas && cyc >= n) && t < timeout) begin
            step();
            t++;
        end
        chk("meas_len", cyc, n);
        meas  = 1'b0;
        armed = 1'b0;
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    initial begin
        sys_rst = 1'b1;
        bus.enable = 1'b0; bus.src_valid = 1'b0; bus.src_data = 24'd0;
        mode = 0; drop_at = -1; ready_cnt = 0; xfer_pend = 1'b0; pix_exp = 0;
        armed = 1'b0; meas = 1'b0; vs_prev = 1'b0; href_prev = 1'b0;
        clear_stats();

        // reset state
        repeat (2) @(negedge sys_clk);
        chk("rst_vsync", int'(bus.per_frame_vsync), 0);
        chk("rst_href",  int'(bus.per_frame_href), 0);
        chk("rst_clken", int'(bus.per_frame_clken), 0);
        chk("rst_data",  int'(bus.pix_data_out), 0);
        chk("rst_busy",  int'(bus.frame_busy), 0);
        chk("rst_done",  int'(bus.frame_done), 0);
        chk("rst_ready", int'(bus.src_ready), 0);
        #2 sys_rst = 1'b0;

        // enable low throughout: nothing moves, random src_data ignored
        mode = 2;
        clear_stats();
        meas = 1'b1;
        repeat (12) step();
        meas = 1'b0;
        chk("idle_ready", n_ready, 0);
        chk("idle_vsync", n_vs, 0);
        chk("idle_href",  n_href, 0);
        chk("idle_clken", n_clk, 0);
        chk("idle_busy",  n_busy, 0);
        chk("idle_data",  int'(bus.pix_data_out), 0);

        // free-running frame: 28 vsync-high + 3 low, lines at 5/11/17
        mode = 0;
        bus.src_data = 24'd0;
        pix_exp = 0;
        bus.enable = 1'b1;
        measure(31, 60);
        chk("free_vsync",  n_vs, 28);
        chk("free_href",   n_href, 12);
        chk("free_clken",  n_clk, 12);
        chk("free_ne",     ne_cnt, 0);
        chk("free_inv",    inv_err, 0);
        chk("free_nlines", rises.size(), 3);
        chk("free_rise0",  qat(rises, 0), 5);
        chk("free_rise1",  qat(rises, 1), 11);
        chk("free_rise2",  qat(rises, 2), 17);
        chk("free_hlen0",  qat(hlens, 0), 4);
        chk("free_hlen2",  qat(hlens, 2), 4);
        chk("free_done",   n_done, 1);
        chk("free_doneat", done_at, 27);
        chk("free_busy",   n_busy, 31);
        step();
        chk("free_period", int'(bus.per_frame_vsync), 1);

        // backpressure: stall every 3rd ready cycle, lines 5/6/6 long
        mode = 1;
        measure(33, 100);
        chk("stall_vsync",  n_vs, 33);
        chk("stall_href",   n_href, 17);
        chk("stall_clken",  n_clk, 12);
        chk("stall_inv",    inv_err, 0);
        chk("stall_hlen0",  qat(hlens, 0), 5);
        chk("stall_hlen1",  qat(hlens, 1), 6);
        chk("stall_hlen2",  qat(hlens, 2), 6);
        chk("stall_rise1",  qat(rises, 1), 12);
        chk("stall_rise2",  qat(rises, 2), 20);
        chk("stall_doneat", done_at, 32);

        // enable dropped mid-LINE: frame completes, then IDLE
        mode = 0;
        drop_at = 7;
        measure(40, 100);
        drop_at = -1;
        chk("drop_vsync", n_vs, 28);
        chk("drop_clken", n_clk, 12);
        chk("drop_lines", rises.size(), 3);
        chk("drop_done",  n_done, 1);
        chk("drop_busy",  n_busy, 31);
        chk("drop_idle_busy",  int'(bus.frame_busy), 0);
        chk("drop_idle_ready", int'(bus.src_ready), 0);

        // one-cycle enable pulse in IDLE: exactly one frame
        bus.enable = 1'b1;
        step();
        bus.enable = 1'b0;
        measure(45, 60);
        chk("pulse_vsync", n_vs, 28);
        chk("pulse_clken", n_clk, 12);
        chk("pulse_lines", rises.size(), 3);
        chk("pulse_done",  n_done, 1);
        chk("pulse_busy",  n_busy, 31);
        chk("pulse_idle_busy", int'(bus.frame_busy), 0);

        // asynchronous reset between edges in the middle of a line
        bus.enable = 1'b1;
        for (int i = 0; i < 40 && !bus.per_frame_href; i++) step();
        step();
        chk("pre_rst_href", int'(bus.per_frame_href), 1);
        #2 sys_rst = 1'b1;
        #1;
        chk("arst_vsync", int'(bus.per_frame_vsync), 0);
        chk("arst_href",  int'(bus.per_frame_href), 0);
        chk("arst_clken", int'(bus.per_frame_clken), 0);
        chk("arst_data",  int'(bus.pix_data_out), 0);
        chk("arst_busy",  int'(bus.frame_busy), 0);
        chk("arst_done",  int'(bus.frame_done), 0);
        chk("arst_ready", int'(bus.src_ready), 0);
        xfer_pend = 1'b0;
        pix_exp = int'(bus.src_data);
        @(negedge sys_clk);
        #2 sys_rst = 1'b0;
        measure(31, 60);
        chk("rst_frame_vsync", n_vs, 28);
        chk("rst_frame_clken", n_clk, 12);
        chk("rst_frame_rise0", qat(rises, 0), 5);
        chk("rst_frame_rise2", qat(rises, 2), 17);
        chk("rst_frame_done",  n_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pix_stream_source.md
# pix_stream_source

Frame-timing transmitter for the pixel-stream interface consumed by the image-processing chain (RGB→gray, frame difference, erosion). Pulls RGB888 pixels from an upstream buffer over a valid/ready handshake. Emits them with `per_frame_vsync` / `per_frame_href` / `per_frame_clken` framing, with programmable vertical and horizontal blanking. Sits at the head of the processing pipeline as the source for both the live-frame and reference-frame ports.

## Interface
- `IMG_HDISP`, 10'd640: active pixels per line (1..1023).
- `IMG_VDISP`, 10'd480: active lines per frame (1..1023).
- `H_BLANK`, 16'd160: href-low cycles after every active line (≥1).
- `V_PRE`, 16'd1000: vsync-high, href-low cycles before the first line (≥1).
- `V_POST`, 16'd1000: vsync-high, href-low cycles after the last line's blank (≥1).
- `V_GAP`, 16'd2000: vsync-low cycles between frames (≥1).
- `sys_clk`  in  1  sole clock.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  level; a frame starts when high in IDLE, and the current frame always completes.
- `src_valid`  in  1  upstream pixel available.
- `src_data`  in  24  upstream RGB888 pixel.
- `src_ready`  out  1  combinational; high in LINE while pixels remain.
- `per_frame_vsync`  out  1  frame-valid.
- `per_frame_href`  out  1  line-valid.
- `per_frame_clken`  out  1  pixel strobe.
- `pix_data_out`  out  24  pixel, valid when clken=1.
- `frame_busy`  out  1  state≠IDLE (registered).
- `frame_done`  out  1  one-cycle pulse at end of V_POST.

## Operation
- States: IDLE, V_PRE, LINE, H_BLANK, V_POST, V_GAP.
- IDLE: when `enable`=1 → V_PRE.
- V_PRE: run `V_PRE` cycles → LINE; clear `line_cnt`.
- LINE: `src_ready`=1 while `pix_cnt` < IMG_HDISP.
  - Transfer = `src_valid & src_ready`; each transfer increments `pix_cnt`.
  - `src_valid`=0 inserts a gap: href stays high, clken low.
  - Transfer of pixel IMG_HDISP-1 → H_BLANK; `pix_cnt` clears and `line_cnt` increments.
- H_BLANK: run `H_BLANK` cycles.
  - If `line_cnt` < IMG_VDISP → LINE.
  - Otherwise → V_POST.
- V_POST: run `V_POST` cycles.
  - On the last cycle, `frame_done` (registered) pulses the following cycle.
  - Then → V_GAP.
- V_GAP: run `V_GAP` cycles.
  - If `enable`=1 → V_PRE.
  - Otherwise → IDLE.
- `enable` deassertion mid-frame has no effect until the end of V_GAP.
- Registered outputs, all one cycle after the state/handshake that causes them:
  - vsync <= state ∈ {V_PRE, LINE, H_BLANK, V_POST}
  - href <= (state==LINE)
  - clken <= transfer
  - `pix_data_out` <= `src_data` on transfer; otherwise holds its value.
- Counters: `pix_cnt` and `line_cnt` are 10-bit; the blank counter is 16-bit, counting 0..N-1 with no wrap beyond N-1.
- Invariants: clken ⇒ href ⇒ vsync. Exactly IMG_HDISP clken per href pulse and IMG_VDISP href pulses per vsync pulse.

## Timing
- Reset: state IDLE, all counters 0, all outputs 0. `src_ready` falls immediately on reset assertion, since it is combinational from state.
- Reset mid-frame aborts the frame; no `frame_done` is produced.
- Enable sampled at edge k → vsync high after edge k+1.
- Latency src→out: 1 cycle.
- Frame period with `src_valid` held high and `enable` held high:
  - V_PRE + IMG_VDISP·(IMG_HDISP+H_BLANK) + V_POST + V_GAP.
  - vsync is low for exactly V_GAP cycles of that period.
- Each upstream stall cycle lengthens href by one cycle.
- Output throughput: 1 pixel/cycle maximum.

## Test plan
All scenarios use IMG_HDISP=4, IMG_VDISP=3, H_BLANK=2, V_PRE=5, V_POST=5, V_GAP=3.
- Free-running frames (`src_valid`=1, `enable`=1, `src_data`=incrementing count from 0) → per frame:
  - vsync high 28 cycles, low 3;
  - 3 href pulses of 4 cycles each, separated by 2 low cycles;
  - clken==href;
  - data 0..11 in order;
  - `frame_done` once per 31-cycle period.
- Backpressure (`src_valid` low every 3rd cycle in LINE) → still 4 clken per line, href stretched by 1 cycle per stall, no duplicated or dropped pixels.
- `enable` pulsed 1 cycle in IDLE → exactly one frame, then IDLE with `frame_busy`=0. `enable` dropped mid-LINE → frame completes with 12 pixels, then IDLE.
- Async reset asserted mid-LINE, between clock edges → all outputs 0 and `src_ready`=0 immediately. After release with `enable`=1, the next frame restarts from V_PRE with `line_cnt`=0.
- `enable`=0 throughout → `src_ready`, vsync, href, clken stay 0 and no transfers occur; `src_data` changes do not alter `pix_data_out`.
